// File: rtl/aes_dec_pkg.sv
// Shared types and GF(2^8) helpers for the AES decryption round stages.
// State vectors use ascending [0:127] order: byte k = bits [8k:8k+7].
package aes_dec_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MIX  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam int NUM_COLS = 4;
    localparam int COL_W    = 32;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // The inverse-mix coefficients are built from b*2, b*4 and b*8.
    function automatic logic [7:0] gmul9(input logic [7:0] b);
        logic [7:0] x8;
        x8 = xtime(xtime(xtime(b)));
        return x8 ^ b;
    endfunction

    function automatic logic [7:0] gmul11(input logic [7:0] b);
        logic [7:0] x2;
        logic [7:0] x8;
        x2 = xtime(b);
        x8 = xtime(xtime(x2));
        return x8 ^ x2 ^ b;
    endfunction

    function automatic logic [7:0] gmul13(input logic [7:0] b);
        logic [7:0] x4;
        logic [7:0] x8;
        x4 = xtime(xtime(b));
        x8 = xtime(x4);
        return x8 ^ x4 ^ b;
    endfunction

    function automatic logic [7:0] gmul14(input logic [7:0] b);
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ x2;
    endfunction

    function automatic logic [0:31] col_slice(input logic [0:127] s, input logic [1:0] c);
        return s[{c, 5'b00000} +: 32];
    endfunction

endpackage

// File: rtl/inv_mix_column.sv
// Combinational InvMixColumns on one 32-bit column; a0 occupies bits [0:7].
module inv_mix_column
    import aes_dec_pkg::*;
(
    input  logic [0:31] col_in,
    output logic [0:31] col_out
);

    logic [7:0] a0, a1, a2, a3;

    assign a0 = col_in[0:7];
    assign a1 = col_in[8:15];
    assign a2 = col_in[16:23];
    assign a3 = col_in[24:31];

    assign col_out[0:7]   = gmul14(a0) ^ gmul11(a1) ^ gmul13(a2) ^ gmul9(a3);
    assign col_out[8:15]  = gmul9(a0)  ^ gmul14(a1) ^ gmul11(a2) ^ gmul13(a3);
    assign col_out[16:23] = gmul13(a0) ^ gmul9(a1)  ^ gmul14(a2) ^ gmul11(a3);
    assign col_out[24:31] = gmul11(a0) ^ gmul13(a1) ^ gmul9(a2)  ^ gmul14(a3);

endmodule

// File: rtl/inv_mix_add_key.sv
// AddRoundKey followed by InvMixColumns, with a valid/ready hold stage on the output.
// Define INV_MIX_PARALLEL_EN to transform all four columns in one cycle instead of one per cycle.
module inv_mix_add_key
    import aes_dec_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [0:127] in_state,
    input  logic [0:127] in_key,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:127] out_state,
    output logic         busy
);

    state_t       state;
    state_t       state_next;
    logic [0:127] work;

`ifdef INV_MIX_PARALLEL_EN
    logic [0:127] mix_all;

    for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
        inv_mix_column u_col (
            .col_in  (work[c*COL_W +: COL_W]),
            .col_out (mix_all[c*COL_W +: COL_W])
        );
    end
`else
    logic [1:0]  col;
    logic [0:31] mix_in;
    logic [0:31] mix_out;

    assign mix_in = col_slice(work, col);

    inv_mix_column u_col (
        .col_in  (mix_in),
        .col_out (mix_out)
    );
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (in_valid) begin
                    state_next = in_last ? ST_HOLD : ST_MIX;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_MIX: begin
`ifdef INV_MIX_PARALLEL_EN
                state_next = ST_HOLD;
`else
                if (col == 2'd3) begin
                    state_next = ST_HOLD;
                end else begin
                    state_next = ST_MIX;
                end
`endif
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_next = ST_IDLE;
                end else begin
                    state_next = ST_HOLD;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Handshake and status outputs decoded from the state register.
    always_comb begin
        in_ready  = (state == ST_IDLE);
        out_valid = (state == ST_HOLD);
        busy      = (state == ST_MIX) || (state == ST_HOLD);
    end

    // Work register: key XOR on accept, column writeback while mixing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            work <= 128'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        work <= in_state ^ in_key;
                    end
                end
`ifdef INV_MIX_PARALLEL_EN
                ST_MIX:  work <= mix_all;
`else
                ST_MIX:  work[{col, 5'b00000} +: 32] <= mix_out;
`endif
                default: work <= work;
            endcase
        end
    end

`ifndef INV_MIX_PARALLEL_EN
    // Column counter; wraps back to 0 after the last column.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col <= 2'd0;
        end else if (state == ST_IDLE) begin
            col <= 2'd0;
        end else if (state == ST_MIX) begin
            col <= col + 2'd1;
        end else begin
            col <= col;
        end
    end
`endif

    assign out_state = work;

endmodule

// File: tb/tb_inv_mix_add_key.sv
// Directed and model-based bench for inv_mix_add_key; honours INV_MIX_PARALLEL_EN.
module tb_inv_mix_add_key;

`ifdef INV_MIX_PARALLEL_EN
    localparam int LAT_MIX = 2;
`else
    localparam int LAT_MIX = 5;
`endif

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [0:127] in_state;
    logic [0:127] in_key;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [0:127] out_state;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;

    inv_mix_add_key dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .in_key    (in_key),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] gm(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] p;
        a = a_in;
        b = b_in;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [0:127] model(input logic [0:127] st, input logic [0:127] key, input logic last);
        logic [0:127] w;
        logic [7:0]   a0, a1, a2, a3;
        w = st ^ key;
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                a0 = w[32*c +: 8];
                a1 = w[32*c+8 +: 8];
                a2 = w[32*c+16 +: 8];
                a3 = w[32*c+24 +: 8];
                w[32*c +: 8]    = gm(a0, 8'd14) ^ gm(a1, 8'd11) ^ gm(a2, 8'd13) ^ gm(a3, 8'd9);
                w[32*c+8 +: 8]  = gm(a0, 8'd9)  ^ gm(a1, 8'd14) ^ gm(a2, 8'd11) ^ gm(a3, 8'd13);
                w[32*c+16 +: 8] = gm(a0, 8'd13) ^ gm(a1, 8'd9)  ^ gm(a2, 8'd14) ^ gm(a3, 8'd11);
                w[32*c+24 +: 8] = gm(a0, 8'd11) ^ gm(a1, 8'd13) ^ gm(a2, 8'd9)  ^ gm(a3, 8'd14);
            end
        end
        return w;
    endfunction

    // Present a block, wait (bounded) for in_ready, and pass the accept edge.
    task automatic accept(input logic [0:127] st, input logic [0:127] key, input logic last);
        int n;
        in_state = st;
        in_key   = key;
        in_last  = last;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("accept_ready", 128'(in_ready), 128'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Count cycles from the accept edge until out_valid rises and check the result.
    task automatic wait_out(input string tag, input int lat_exp, input logic [0:127] exp);
        int lat;
        lat = 1;
        while (!out_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_eq({tag, "_lat"}, 128'(lat), 128'(lat_exp));
        check_eq({tag, "_data"}, out_state, exp);
    endtask

    task automatic drain(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_eq({tag, "_drain_valid"}, 128'(out_valid), 128'd0);
        check_eq({tag, "_drain_ready"}, 128'(in_ready), 128'd1);
    endtask

    initial begin
        logic [0:127] v1, e1, k2, v2, e2, a, b, st, key, exp;
        logic         last;

        v1 = {4{32'h8e4da1bc}};
        e1 = {4{32'hdb135345}};
        k2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        v2 = {4{32'h9fdc589d}};
        e2 = {4{32'hf20a225c}};
        a  = 128'h00112233445566778899aabbccddeeff;
        b  = 128'h0f0e0d0c0b0a09080706050403020100;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_state  = 128'd0;
        in_key    = 128'd0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_eq("rst_in_ready", 128'(in_ready), 128'd1);
        check_eq("rst_out_valid", 128'(out_valid), 128'd0);
        check_eq("rst_busy", 128'(busy), 128'd0);
        check_eq("rst_out_state", out_state, 128'd0);

        // Vector 1, key 0.
        accept(v1, 128'd0, 1'b0);
        check_eq("v1_busy", 128'(busy), 128'd1);
        wait_out("v1", LAT_MIX, e1);
        drain("v1");

        // Vector 2 with a non-zero key.
        accept(v2 ^ k2, k2, 1'b0);
        wait_out("v2", LAT_MIX, e2);
        drain("v2");

        // Fixed points.
        accept({4{32'hc6c6c6c6}}, 128'd0, 1'b0);
        wait_out("fix_c6", LAT_MIX, {4{32'hc6c6c6c6}});
        drain("fix_c6");
        accept({4{32'h01010101}}, 128'd0, 1'b0);
        wait_out("fix_01", LAT_MIX, {4{32'h01010101}});
        drain("fix_01");

        // Final round: AddRoundKey only.
        accept(a, b, 1'b1);
        wait_out("last", 1, 128'h0f1f2f3f4f5f6f7f8f9fafbfcfdfefff);
        drain("last");

        // Backpressure in HOLD.
        accept(v1, 128'd0, 1'b0);
        wait_out("bp", LAT_MIX, e1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check_eq("bp_valid", 128'(out_valid), 128'd1);
            check_eq("bp_data", out_state, e1);
            check_eq("bp_in_ready", 128'(in_ready), 128'd0);
        end
        drain("bp");

        // Reset after E2.
        accept(v2, 128'd0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_eq("mid_rst_valid", 128'(out_valid), 128'd0);
        check_eq("mid_rst_state", out_state, 128'd0);
        check_eq("mid_rst_busy", 128'(busy), 128'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        accept(v1, 128'd0, 1'b0);
        wait_out("post_rst", LAT_MIX, e1);
        drain("post_rst");

        // Back-to-back random blocks; the next block is presented while busy.
        st   = {$urandom, $urandom, $urandom, $urandom};
        key  = {$urandom, $urandom, $urandom, $urandom};
        last = 1'b0;
        for (int i = 0; i < 8; i++) begin
            exp = model(st, key, last);
            accept(st, key, last);
            st   = {$urandom, $urandom, $urandom, $urandom};
            key  = {$urandom, $urandom, $urandom, $urandom};
            in_state = st;
            in_key   = key;
            in_valid = 1'b1;
            wait_out("rand", last ? 1 : LAT_MIX, exp);
            last = (i % 3 == 1);
            in_last = last;
            drain("rand");
        end
        in_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
